// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 round-key storage.
// The half_we helper maps the write pointer's LSB onto the RAM's half-word enables.
package aes_pkg;
  localparam int AES_NUM_ROUND_KEYS = 11;
  localparam int AES_KEY_W          = 128;
  localparam int AES_HALF_W         = 64;

  typedef logic [AES_KEY_W-1:0] round_key_t;

  // Even half-pointer fills the upper half of a key, odd fills the lower half.
  function automatic logic [1:0] half_we(input logic wr_lsb);
    return wr_lsb ? 2'b01 : 2'b10;
  endfunction
endpackage

// File: rtl/aes_keyram_bram.sv
// Simple dual-port RAM with half-word write enables and a read-first registered read port.
// Contents power up to zero and are never cleared by rst; rst only clears the read register.
module aes_keyram_bram
  import aes_pkg::*;
#(
  parameter int DEPTH = AES_NUM_ROUND_KEYS,
  parameter int W     = AES_KEY_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);
  localparam int HW = W / 2;

  logic [W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en[1]) r_mem[i_wr_addr][W-1:HW] <= i_wr_data[W-1:HW];
    if (i_wr_en[0]) r_mem[i_wr_addr][HW-1:0] <= i_wr_data[HW-1:0];
  end

  // Separate process from the write so a same-address read sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/aes_128_keyram.sv
// AES-128 round-key store: key expansion writes 64-bit halves, the round datapath
// reads a full registered 128-bit key and steps to the next one on each key_ready.
module aes_128_keyram
  import aes_pkg::*;
#(
  parameter int NUM_KEYS = AES_NUM_ROUND_KEYS,
  parameter int HALF_W   = AES_HALF_W
) (
  input  logic                clk,
  input  logic                kill,
  input  logic                en_wr,
  input  logic [HALF_W-1:0]   key_round_wr,
  input  logic                key_ready,
  output logic [2*HALF_W-1:0] key_round_rd
);
  localparam int WPW = $clog2(2 * NUM_KEYS);
  localparam int RPW = $clog2(NUM_KEYS);
  localparam logic [WPW-1:0] WR_LAST = WPW'(2 * NUM_KEYS - 1);
  localparam logic [RPW-1:0] RD_LAST = RPW'(NUM_KEYS - 1);

  logic [WPW-1:0]      r_wr_ptr;
  logic [RPW-1:0]      r_rd_ptr;
  logic [1:0]          w_we;
  logic [2*HALF_W-1:0] w_wr_data;
  logic [2*HALF_W-1:0] w_rd_data;

  // A write coinciding with a reset edge is discarded.
  assign w_we      = (en_wr && !kill) ? half_we(r_wr_ptr[0]) : 2'b00;
  assign w_wr_data = {2{key_round_wr}};

  always_ff @(posedge clk or posedge kill) begin
    if (kill)       r_wr_ptr <= '0;
    else if (en_wr) r_wr_ptr <= (r_wr_ptr == WR_LAST) ? '0 : r_wr_ptr + WPW'(1);
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill)           r_rd_ptr <= '0;
    else if (key_ready) r_rd_ptr <= (r_rd_ptr == RD_LAST) ? '0 : r_rd_ptr + RPW'(1);
  end

  aes_keyram_bram #(
    .DEPTH (NUM_KEYS),
    .W     (2 * HALF_W),
    .AW    (RPW)
  ) u_bram (
    .clk       (clk),
    .rst       (kill),
    .i_wr_en   (w_we),
    .i_wr_addr (r_wr_ptr[WPW-1:1]),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign key_round_rd = w_rd_data;
endmodule

// File: tb/tb_aes_128_keyram.sv
// Directed bench for aes_128_keyram: a reference model pushes the expected read word
// on every clock edge and the scoreboard pops it half a cycle later.
module tb_aes_128_keyram;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        kill;
  logic        enWr;
  logic [63:0] keyRoundWr;
  logic        keyReady;
  round_key_t  keyRoundRd;

  always #5 clk = ~clk;

  aes_128_keyram dut (
    .clk          (clk),
    .kill         (kill),
    .en_wr        (enWr),
    .key_round_wr (keyRoundWr),
    .key_ready    (keyReady),
    .key_round_rd (keyRoundRd)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  round_key_t modelMem [11];
  int         modelWr;
  int         modelRd;
  round_key_t expQ [$];

  localparam round_key_t K0 = 128'hFFFFFFFFFFFFFFFF_AAAAAAAAAAAAAAAA;

  function automatic logic [63:0] patt(input int r, input int h);
    return {24'hA5A5A5, 8'(r), 24'h5A5A5A, 8'(h)};
  endfunction

  task automatic checkOutput(input string tag, input round_key_t expected);
    checkCount++;
    assert (keyRoundRd === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, keyRoundRd, expected);
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and scores the resulting read.
  task automatic applyStimulus(input logic en, input logic [63:0] data, input logic rdy,
                               input string tag);
    enWr = en; keyRoundWr = data; keyReady = rdy;
    @(posedge clk);
    expQ.push_back(modelMem[modelRd]);
    if (en) begin
      if (modelWr % 2 == 0) modelMem[modelWr / 2][127:64] = data;
      else                  modelMem[modelWr / 2][63:0]   = data;
      modelWr = (modelWr + 1) % 22;
    end
    if (rdy) modelRd = (modelRd + 1) % 11;
    @(negedge clk);
    enWr = 1'b0; keyReady = 1'b0; keyRoundWr = '0;
    if (expQ.size() == 0) begin
      checkCount++; failCount++;
      $display("[TB] FAIL %s: scoreboard empty, observed %h expected a queued entry", tag, keyRoundRd);
    end else begin
      checkOutput(tag, expQ.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 11; i++) modelMem[i] = '0;
    modelWr = 0; modelRd = 0;
    kill = 1'b0; enWr = 1'b0; keyRoundWr = '0; keyReady = 1'b0;

    // Power-up reset
    #2 kill = 1'b1;
    #1 checkOutput("resetOut", '0);
    #50;
    @(negedge clk);
    kill = 1'b0;
    applyStimulus(0, '0, 0, "postReset");
    checkOutput("postResetZero", '0);

    // Read pointer wraps over an empty RAM
    for (int r = 0; r < 11; r++) begin
      applyStimulus(0, '0, 1, "emptyPulse");
      for (int k = 0; k < 3; k++) applyStimulus(0, '0, 0, "emptyIdle");
      checkOutput("emptyRound", '0);
    end

    // Two half-writes into round 0
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "writeHi");
    applyStimulus(0, '0, 0, "idleAfterHi");
    checkOutput("upperVisible", 128'hFFFFFFFFFFFFFFFF_0000000000000000);
    applyStimulus(1, 64'hAAAA_AAAA_AAAA_AAAA, 0, "writeLo");
    applyStimulus(0, '0, 0, "idleAfterLo");
    checkOutput("fullKey0", K0);

    for (int r = 1; r <= 11; r++) begin
      applyStimulus(0, '0, 1, "seqPulse");
      applyStimulus(0, '0, 0, "seqIdle");
      checkOutput("seqRound", (r == 11) ? K0 : '0);
    end

    // Reset mid-sequence with a write in flight: pointers clear, RAM retained
    enWr = 1'b1; keyRoundWr = 64'hDEAD_BEEF_DEAD_BEEF; kill = 1'b1;
    #1 checkOutput("killImmediate", '0);
    modelWr = 0; modelRd = 0;
    repeat (3) @(negedge clk);
    enWr = 1'b0; keyRoundWr = '0; kill = 1'b0;
    applyStimulus(0, '0, 0, "afterKill");
    checkOutput("killRetains", K0);

    // Fill all 22 halves, then read every round back
    for (int i = 0; i < 22; i++) applyStimulus(1, patt(i / 2, i % 2), 0, "fillWrite");
    applyStimulus(0, '0, 0, "fillIdle");
    checkOutput("fillRound0", {patt(0, 0), patt(0, 1)});
    for (int r = 1; r <= 11; r++) begin
      applyStimulus(0, '0, 1, "fillPulse");
      applyStimulus(0, '0, 0, "fillIdle");
      checkOutput("fillRound", {patt(r % 11, 0), patt(r % 11, 1)});
    end

    // 23rd write wraps onto round 0 upper half; same-address read is read-first
    applyStimulus(1, 64'h1234_5678_9ABC_DEF0, 0, "wrapWrite");
    checkOutput("readFirstOld", {patt(0, 0), patt(0, 1)});
    applyStimulus(0, '0, 0, "wrapIdle");
    checkOutput("wrapNew", {64'h1234_5678_9ABC_DEF0, patt(0, 1)});

    // Simultaneous write and key_ready advance both pointers
    applyStimulus(1, 64'h0F0F_0F0F_0F0F_0F0F, 1, "bothStrobes");
    checkOutput("bothOld", {64'h1234_5678_9ABC_DEF0, patt(0, 1)});
    applyStimulus(0, '0, 0, "bothIdle");
    checkOutput("bothRdAdvanced", {patt(1, 0), patt(1, 1)});
    applyStimulus(1, 64'h3C3C_3C3C_3C3C_3C3C, 0, "wrAdvanced");
    applyStimulus(0, '0, 0, "wrAdvIdle");
    checkOutput("wrAdvancedWord1", {64'h3C3C_3C3C_3C3C_3C3C, patt(1, 1)});
    for (int r = 0; r < 10; r++) applyStimulus(0, '0, 1, "backToZero");
    applyStimulus(0, '0, 0, "round0Idle");
    checkOutput("round0Lower", {64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
